latency_pop_stream: RTL
=======================

LATENCY_POP_STREAM -- requirements
Module: latency_pop_stream

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The module SHALL have parameter READ_DATA_LATENCY, default 2, giving the cycles from pop to valid pop_data (legal range 1..4).
REQ-003 The module SHALL have a derived localparam BUF_DEPTH = READ_DATA_LATENCY+1, giving the return-buffer entries.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port may_pop, input, 1 bit: the upstream FIFO is non-empty.
REQ-007 The module SHALL have port pop, output, 1 bit: pop request to the upstream FIFO.
REQ-008 The module SHALL have port pop_data, input, WIDTH bits: upstream data, valid exactly READ_DATA_LATENCY cycles after pop.
REQ-009 The module SHALL have port out_valid, output, 1 bit: stream data valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: stream consumer ready.
REQ-011 The module SHALL have port out_data, output, WIDTH bits: stream data, which is the head of the return buffer.

Function
REQ-012 The block SHALL track count = buffer occupancy + pops in flight, where 0 <= count <= BUF_DEPTH at all times.
REQ-013 The block SHALL assert pop = may_pop && (count < BUF_DEPTH || (out_valid && out_ready)) combinationally; this is the only ready-to-pop path.
REQ-014 In-flight tracking SHALL be a READ_DATA_LATENCY-bit shift register fed by pop; when the final stage is 1, pop_data SHALL be written to the buffer tail that cycle.
REQ-015 A transfer SHALL occur when out_valid && out_ready, and it removes the buffer head.
REQ-016 out_valid SHALL equal occupancy != 0, with no added latency from a buffer write to out_valid beyond the registered write (data visible the cycle after arrival).
REQ-017 out_data SHALL hold stable while out_valid && !out_ready.
REQ-018 Data order SHALL equal pop order, with no loss and no duplication.
REQ-019 A simultaneous arrival and transfer SHALL leave occupancy unchanged, with head and tail both advancing.
REQ-020 A simultaneous pop and transfer at count == BUF_DEPTH SHALL keep count == BUF_DEPTH.
REQ-021 The block SHALL sustain one word per cycle when may_pop and out_ready are held high.
REQ-022 Buffer pointers SHALL wrap modulo BUF_DEPTH.
REQ-023 The block SHALL never write the buffer when it is full; this is guaranteed by REQ-012.

Reset
REQ-024 On rst low, the block SHALL asynchronously clear the in-flight shift register, occupancy and pointers; out_valid = 0 and pop = 0 while rst is low.
REQ-025 A reset mid-operation SHALL discard buffered and in-flight words; the upstream FIFO SHALL be reset concurrently by the system.
REQ-026 out_data SHALL read 0 after reset (storage cleared).

Configuration
REQ-027 With LATENCY_POP_STREAM_DBG_EN defined, the block SHALL add output dbg_pop_count (32 bits), which counts asserted pop cycles, wraps at 2^32, and resets to 0.
REQ-028 Without LATENCY_POP_STREAM_DBG_EN, the port and counter SHALL be absent, with no other behavioural difference.

Structure
REQ-029 Package latency_pop_stream_pkg SHALL hold the MAX_READ_DATA_LATENCY = 4 constant and the DBG_COUNT_WIDTH = 32 constant.
REQ-030 The return buffer SHALL be a sub-module pop_return_buf (a WIDTH x BUF_DEPTH circular buffer exposing write, read, head, and occupancy).
REQ-031 Credit and in-flight logic SHALL stay in latency_pop_stream.

Verification
REQ-032 Streaming: L=2, may_pop=1, out_ready=1, with words 1..10 -> pop high every cycle, first out_valid at cycle 3 after the first pop, outputs 1..10 consecutively.
REQ-033 Backpressure: L=2, out_ready=0 -> exactly 3 pops then pop=0; out_data stays 1; raising out_ready -> words 1,2,3 then resume at 1 word per cycle.
REQ-034 Empty upstream: may_pop toggling 1,0,1,0 -> pops only on may_pop=1 cycles; out_valid pattern delayed by L+1; no spurious words.
REQ-035 Full boundary: count=3, out_ready=1 and may_pop=1 in the same cycle -> pop=1 and count stays 3.
REQ-036 Mid-flight reset: rst low one cycle after 2 pops -> out_valid=0 immediately; after release, no stale words appear.
REQ-037 DBG: LATENCY_POP_STREAM_DBG_EN defined, 7 pops -> dbg_pop_count=7; macro undefined -> elaboration succeeds without the port.

Source files
------------

// File: rtl/latency_pop_stream_pkg.sv
// Shared constants for latency_pop_stream and its return buffer.
// Build option LATENCY_POP_STREAM_DBG_EN sizes the debug pop counter from here.
package latency_pop_stream_pkg;

    localparam int unsigned MAX_READ_DATA_LATENCY = 4;
    localparam int unsigned DBG_COUNT_WIDTH       = 32;

    typedef logic [DBG_COUNT_WIDTH-1:0] dbg_count_t;

endpackage

// File: rtl/pop_return_buf.sv
// Circular return buffer: WIDTH x DEPTH, written at the tail, read at the head.
// Storage is cleared on reset so the head reads zero when empty after reset.
module pop_return_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write,
    input  logic [WIDTH-1:0]           write_data,
    input  logic                       read,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Depth is generally not a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (write) begin
                mem[wr_ptr] <= write_data;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (read) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            if (write && !read) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (!write && read) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/latency_pop_stream.sv
// Converts a fixed-read-latency FIFO pop interface into a valid/ready stream.
// Define LATENCY_POP_STREAM_DBG_EN to add the dbg_pop_count output.
module latency_pop_stream
    import latency_pop_stream_pkg::*;
#(
    parameter int unsigned WIDTH             = 8,
    parameter int unsigned READ_DATA_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       may_pop,
    output logic                       pop,
    input  logic [WIDTH-1:0]           pop_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data
`ifdef LATENCY_POP_STREAM_DBG_EN
    ,
    output logic [DBG_COUNT_WIDTH-1:0] dbg_pop_count
`endif
);

    localparam int unsigned BUF_DEPTH = READ_DATA_LATENCY + 1;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);

    logic [READ_DATA_LATENCY-1:0] inflight;
    logic [CNT_W-1:0]             count;
    logic [CNT_W-1:0]             count_next;
    logic [CNT_W-1:0]             occupancy;
    logic                         xfer;
    logic                         arrive;

    assign xfer   = out_valid && out_ready;
    assign arrive = inflight[READ_DATA_LATENCY-1];

    // Credits cover buffered plus in-flight words, so an arrival always finds room.
    always_comb begin
        pop        = rst && may_pop && ((count < CNT_W'(BUF_DEPTH)) || xfer);
        count_next = count + CNT_W'(pop) - CNT_W'(xfer);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            inflight <= '0;
        end else begin
            count       <= count_next;
            inflight[0] <= pop;
            for (int unsigned i = 1; i < READ_DATA_LATENCY; i++) begin
                inflight[i] <= inflight[i-1];
            end
        end
    end

    pop_return_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .write      (arrive),
        .write_data (pop_data),
        .read       (xfer),
        .head       (out_data),
        .occupancy  (occupancy)
    );

    assign out_valid = (occupancy != '0);

`ifdef LATENCY_POP_STREAM_DBG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_pop_count <= '0;
        end else if (pop) begin
            dbg_pop_count <= dbg_pop_count + DBG_COUNT_WIDTH'(1);
        end
    end
`endif

endmodule
